// File: rtl/rf80386_prefetch_queue.sv
// Instruction-byte prefetch queue between the I-cache bundle port and the decoder.
// Circular byte store with bundle fill, variable consume, flush/redirect and NOP-padded peek.
module rf80386_prefetch_queue #(
    parameter int BUNDLE_BYTES = 16,
    parameter int DEPTH_BYTES  = 32,
    parameter int PEEK_BYTES   = 8,
    parameter int CNT_W        = $clog2(DEPTH_BYTES) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [31:0]                   flush_adr_i,
    output logic                          fetch_req_o,
    output logic [31:0]                   fetch_adr_o,
    input  logic [BUNDLE_BYTES*8-1:0]     ibundle_i,
    input  logic                          ihit_i,
    output logic [PEEK_BYTES*8-1:0]       peek_o,
    output logic [CNT_W-1:0]              avail_o,
    output logic [31:0]                   head_adr_o,
    input  logic [$clog2(PEEK_BYTES):0]   consume_i,
    output logic                          ovc_o
);

    localparam int              PTR_W     = $clog2(DEPTH_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH_BYTES);
    localparam logic [CNT_W-1:0] BUNDLE_C = CNT_W'(BUNDLE_BYTES);
    localparam logic [31:0]     RESET_ADR = 32'hFFFF_0000;

    logic [7:0]       mem_q [DEPTH_BYTES];
    logic [7:0]       mem_d [DEPTH_BYTES];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_adr_q, fetch_adr_d;
    logic [31:0]      head_adr_q, head_adr_d;
    logic             ovc_q, ovc_d;

    logic [CNT_W-1:0] free_s;
    logic [CNT_W-1:0] consume_ext_s;
    logic [CNT_W-1:0] eff_s;
    logic             overrun_s;
    logic             fetch_req_s;
    logic             fill_s;

    // Request and consume qualification from registered occupancy only.
    always_comb begin
        free_s        = DEPTH_C - count_q;
        consume_ext_s = CNT_W'(consume_i);
        overrun_s     = (consume_ext_s > count_q);
        fetch_req_s   = ~rst_i & ~flush_i & (free_s >= BUNDLE_C);
        fill_s        = fetch_req_s & ihit_i;
        if (overrun_s) begin
            eff_s = count_q;
        end else begin
            eff_s = consume_ext_s;
        end
    end

    // Next-state computation; flush overrides both fill and consume.
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_adr_d = fetch_adr_q;
        head_adr_d  = head_adr_q;
        ovc_d       = ovc_q;
        if (flush_i) begin
            rd_ptr_d    = {PTR_W{1'b0}};
            wr_ptr_d    = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            fetch_adr_d = flush_adr_i;
            head_adr_d  = flush_adr_i;
            ovc_d       = 1'b0;
        end else begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(eff_s);
            head_adr_d = head_adr_q + 32'(eff_s);
            if (overrun_s) begin
                ovc_d = 1'b1;
            end else begin
                ovc_d = ovc_q;
            end
            if (fill_s) begin
                for (int k = 0; k < BUNDLE_BYTES; k++) begin
                    mem_d[wr_ptr_q + PTR_W'(k)] = ibundle_i[k*8 +: 8];
                end
                wr_ptr_d    = wr_ptr_q + PTR_W'(BUNDLE_BYTES);
                fetch_adr_d = fetch_adr_q + 32'(BUNDLE_BYTES);
                count_d     = count_q - eff_s + BUNDLE_C;
            end else begin
                count_d = count_q - eff_s;
            end
        end
    end

    // State registers with asynchronous reset to the power-on fetch vector.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH_BYTES; k++) begin
                mem_q[k] <= 8'h00;
            end
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            fetch_adr_q <= RESET_ADR;
            head_adr_q  <= RESET_ADR;
            ovc_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_adr_q <= fetch_adr_d;
            head_adr_q  <= head_adr_d;
            ovc_q       <= ovc_d;
        end
    end

    // Peek window: bytes beyond the valid count read as NOP.
    always_comb begin
        peek_o = {PEEK_BYTES{8'h90}};
        for (int k = 0; k < PEEK_BYTES; k++) begin
            if (CNT_W'(k) < count_q) begin
                peek_o[k*8 +: 8] = mem_q[rd_ptr_q + PTR_W'(k)];
            end else begin
                peek_o[k*8 +: 8] = 8'h90;
            end
        end
    end

    assign fetch_req_o = fetch_req_s;
    assign fetch_adr_o = fetch_adr_q;
    assign avail_o     = count_q;
    assign head_adr_o  = head_adr_q;
    assign ovc_o       = ovc_q;

endmodule

// File: tb/tb_rf80386_prefetch_queue.sv
// Self-checking bench: byte-queue reference model compared every cycle, plus directed literal checks.
module tb_rf80386_prefetch_queue;

    localparam int BB = 16;
    localparam int DB = 32;
    localparam int PB = 8;
    localparam int CW = $clog2(DB) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [31:0]       flush_adr_i;
    logic              fetch_req_o;
    logic [31:0]       fetch_adr_o;
    logic [BB*8-1:0]   ibundle_i;
    logic              ihit_i;
    logic [PB*8-1:0]   peek_o;
    logic [CW-1:0]     avail_o;
    logic [31:0]       head_adr_o;
    logic [3:0]        consume_i;
    logic              ovc_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mq[$];
    logic [31:0] m_head;
    logic [31:0] m_fetch;
    logic        m_ovc;

    always #5 clk_i = ~clk_i;

    rf80386_prefetch_queue #(.BUNDLE_BYTES(BB), .DEPTH_BYTES(DB), .PEEK_BYTES(PB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_adr_i(flush_adr_i),
        .fetch_req_o(fetch_req_o), .fetch_adr_o(fetch_adr_o), .ibundle_i(ibundle_i),
        .ihit_i(ihit_i), .peek_o(peek_o), .avail_o(avail_o), .head_adr_o(head_adr_o),
        .consume_i(consume_i), .ovc_o(ovc_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [BB*8-1:0] mk_bundle(input logic [7:0] base);
        logic [BB*8-1:0] b;
        for (int i = 0; i < BB; i++) b[i*8 +: 8] = base + 8'(i);
        return b;
    endfunction

    function automatic logic [63:0] m_peek();
        logic [63:0] p;
        for (int k = 0; k < PB; k++) p[k*8 +: 8] = (k < mq.size()) ? mq[k] : 8'h90;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head  = 32'hFFFF_0000;
        m_fetch = 32'hFFFF_0000;
        m_ovc   = 1'b0;
    endtask

    // Queue-level reference update at each rising edge.
    task automatic model_edge();
        int cons;
        int eff;
        bit req;
        if (rst_i) begin
            model_reset();
        end else if (flush_i) begin
            mq.delete();
            m_head  = flush_adr_i;
            m_fetch = flush_adr_i;
            m_ovc   = 1'b0;
        end else begin
            req  = (DB - mq.size()) >= BB;
            cons = int'(consume_i);
            eff  = (cons < mq.size()) ? cons : mq.size();
            if (cons > mq.size()) m_ovc = 1'b1;
            repeat (eff) void'(mq.pop_front());
            m_head = m_head + 32'(eff);
            if (req && ihit_i) begin
                for (int i = 0; i < BB; i++) mq.push_back(ibundle_i[i*8 +: 8]);
                m_fetch = m_fetch + 32'(BB);
            end
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = !rst_i && !flush_i && ((DB - mq.size()) >= BB);
        chk("avail", 64'(avail_o), 64'(mq.size()));
        chk("peek", peek_o, m_peek());
        chk("head_adr", 64'(head_adr_o), 64'(m_head));
        chk("fetch_adr", 64'(fetch_adr_o), 64'(m_fetch));
        chk("ovc", 64'(ovc_o), 64'(m_ovc));
        chk("fetch_req", 64'(fetch_req_o), 64'(exp_req));
    endtask

    task automatic drive(input logic hit, input logic [BB*8-1:0] bun, input int cons,
                         input logic fl, input logic [31:0] fadr);
        ihit_i      = hit;
        ibundle_i   = bun;
        consume_i   = 4'(cons);
        flush_i     = fl;
        flush_adr_i = fadr;
        if (rst_i) model_reset();
        #1;
        compare_all();
    endtask

    task automatic finish_cycle();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        rst_i     = 1'b0;
        ihit_i    = 1'b0;
        consume_i = 4'd0;
        flush_i   = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; flush_adr_i = 32'h0;
        ibundle_i = '0; ihit_i = 1'b0; consume_i = 4'd0;
        model_reset();
        #2 rst_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        #1;
        compare_all();
        chk("rst_fetch_req", 64'(fetch_req_o), 64'd0);
        chk("rst_fetch_adr", 64'(fetch_adr_o), 64'hFFFF_0000);
        chk("rst_peek", peek_o, 64'h9090_9090_9090_9090);
        rst_i = 1'b0;
        #1;

        // Test 1: first fill after reset
        drive(1'b1, mk_bundle(8'h00), 0, 1'b0, 32'h0);
        chk("t1_req", 64'(fetch_req_o), 64'd1);
        chk("t1_adr0", 64'(fetch_adr_o), 64'hFFFF_0000);
        finish_cycle();
        chk("t1_avail", 64'(avail_o), 64'd16);
        chk("t1_peek", peek_o, 64'h0706_0504_0302_0100);
        chk("t1_adr1", 64'(fetch_adr_o), 64'hFFFF_0010);

        // Test 2: fill to full, then consume 4
        drive(1'b1, mk_bundle(8'h10), 0, 1'b0, 32'h0);
        finish_cycle();
        chk("t2_avail_full", 64'(avail_o), 64'd32);
        drive(1'b1, mk_bundle(8'hA0), 4, 1'b0, 32'h0);
        chk("t2_req_full", 64'(fetch_req_o), 64'd0);
        finish_cycle();
        chk("t2_avail", 64'(avail_o), 64'd28);
        chk("t2_head", 64'(head_adr_o), 64'hFFFF_0004);
        chk("t2_peek", peek_o, 64'h0B0A_0908_0706_0504);

        // Test 3: simultaneous fill + consume, then read across the pointer wrap
        drive(1'b0, '0, 8, 1'b0, 32'h0);
        finish_cycle();
        drive(1'b0, '0, 4, 1'b0, 32'h0);
        finish_cycle();
        chk("t3_avail16", 64'(avail_o), 64'd16);
        drive(1'b1, mk_bundle(8'h20), 5, 1'b0, 32'h0);
        chk("t3_req", 64'(fetch_req_o), 64'd1);
        finish_cycle();
        chk("t3_avail27", 64'(avail_o), 64'd27);
        chk("t3_head", 64'(head_adr_o), 64'hFFFF_0015);
        drive(1'b0, '0, 8, 1'b0, 32'h0);
        finish_cycle();
        chk("t3_avail19", 64'(avail_o), 64'd19);
        chk("t3_wrap_peek", peek_o, 64'h2423_2221_201F_1E1D);

        // Test 4: consume overrun
        drive(1'b0, '0, 0, 1'b1, 32'h0000_0100);
        finish_cycle();
        drive(1'b1, mk_bundle(8'h40), 0, 1'b0, 32'h0);
        finish_cycle();
        drive(1'b0, '0, 8, 1'b0, 32'h0);
        finish_cycle();
        drive(1'b0, '0, 5, 1'b0, 32'h0);
        finish_cycle();
        chk("t4_avail3", 64'(avail_o), 64'd3);
        chk("t4_head3", 64'(head_adr_o), 64'h0000_010D);
        drive(1'b0, '0, 5, 1'b0, 32'h0);
        finish_cycle();
        chk("t4_avail0", 64'(avail_o), 64'd0);
        chk("t4_head", 64'(head_adr_o), 64'h0000_0110);
        chk("t4_ovc", 64'(ovc_o), 64'd1);
        drive(1'b0, '0, 0, 1'b0, 32'h0);
        finish_cycle();
        chk("t4_ovc_sticky", 64'(ovc_o), 64'd1);

        // Test 5: flush with a bundle arriving in the same cycle
        drive(1'b1, mk_bundle(8'h60), 0, 1'b1, 32'h0000_1234);
        chk("t5_req_flush", 64'(fetch_req_o), 64'd0);
        finish_cycle();
        chk("t5_avail", 64'(avail_o), 64'd0);
        chk("t5_peek", peek_o, 64'h9090_9090_9090_9090);
        chk("t5_fetch", 64'(fetch_adr_o), 64'h0000_1234);
        chk("t5_head", 64'(head_adr_o), 64'h0000_1234);
        chk("t5_ovc", 64'(ovc_o), 64'd0);
        chk("t5_req", 64'(fetch_req_o), 64'd1);

        // Test 6: asynchronous reset mid-fill
        drive(1'b1, mk_bundle(8'h70), 0, 1'b0, 32'h0);
        finish_cycle();
        chk("t6_avail16", 64'(avail_o), 64'd16);
        ihit_i    = 1'b1;
        ibundle_i = mk_bundle(8'h80);
        consume_i = 4'd2;
        #1 rst_i = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("t6_avail", 64'(avail_o), 64'd0);
        chk("t6_fetch", 64'(fetch_adr_o), 64'hFFFF_0000);
        chk("t6_head", 64'(head_adr_o), 64'hFFFF_0000);
        chk("t6_req", 64'(fetch_req_o), 64'd0);
        finish_cycle();
        compare_all();
        chk("t6_post_avail", 64'(avail_o), 64'd0);
        chk("t6_post_peek", peek_o, 64'h9090_9090_9090_9090);

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 9) < 7),
                  {$urandom, $urandom, $urandom, $urandom},
                  int'($urandom_range(0, 9)),
                  ($urandom_range(0, 39) == 0),
                  $urandom);
            finish_cycle();
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
